flag_tracker: RTL

//  Receives the NFlag word the ALU produces each cycle, holds it as the architectural

---
 rtl/flag_tracker_if.sv | 34 +++
 rtl/flag_tracker.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/flag_tracker_if.sv
// flag_tracker_if: bundles the ALU flag path, branch resolution and trap
// handshake signals of flag_tracker.
//   flag_we/nflag/pc_in : ALU result flags and PC of the producing instruction
//   flag                : registered Flag word fed back to the ALU
//   br_eval/br_cond     : branch condition request; br_valid/br_taken reply
//   trap_req/trap_ack   : overflow trap handshake with the controller; epc
//   ovf_cnt             : overflow event count (zero unless FLAG_TRAP_CNT_EN)
// Modports: slave = flag_tracker side, master = controller/ALU side.
interface flag_tracker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             flag_we;
  logic [31:0]      nflag;
  logic [31:0]      pc_in;
  logic [31:0]      flag;
  logic             br_eval;
  logic [2:0]       br_cond;
  logic             br_valid;
  logic             br_taken;
  logic             trap_req;
  logic             trap_ack;
  logic [31:0]      epc;
  logic [CNT_W-1:0] ovf_cnt;

  modport slave (
    input  flag_we, nflag, pc_in, br_eval, br_cond, trap_ack,
    output flag, br_valid, br_taken, trap_req, epc, ovf_cnt
  );

  modport master (
    output flag_we, nflag, pc_in, br_eval, br_cond, trap_ack,
    input  flag, br_valid, br_taken, trap_req, epc, ovf_cnt
  );
endinterface

// File: rtl/flag_tracker.sv
// flag_tracker: architectural Flag register with sticky overflow, forwarded
// branch-condition resolution and an overflow trap req/ack handshake.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : flag_tracker_if.slave (see interface header for signal list)
// Optional feature: define FLAG_TRAP_CNT_EN to build the saturating overflow
// event counter on bus.ovf_cnt; otherwise ovf_cnt is tied to zero.
// Flag bit positions default from FLAG_BIT_ZERO / FLAG_BIT_OVERFLOW.
`ifndef FLAG_BIT_ZERO
`define FLAG_BIT_ZERO 0
`endif
`ifndef FLAG_BIT_OVERFLOW
`define FLAG_BIT_OVERFLOW 1
`endif

module flag_tracker #(
  parameter int unsigned ZERO_BIT = `FLAG_BIT_ZERO,
  parameter int unsigned OVF_BIT  = `FLAG_BIT_OVERFLOW,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  flag_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] flag_q, flag_d;
  logic [31:0] epc_q, epc_d;
  logic        trap_req_q, trap_req_d;
  logic        br_valid_q;
  logic        br_taken_q, br_taken_d;
  logic        ovf_ev;
  logic        ovf_clr;
  logic        eff_z;
  logic        eff_ov;
  logic        cond_res;

  assign ovf_ev = bus.flag_we & bus.nflag[OVF_BIT];

  // Trap FSM
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    trap_req_d = trap_req_q;
    ovf_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ovf_ev) begin
          state_d    = TRAP;
          epc_d      = bus.pc_in;
          trap_req_d = 1'b1;
        end
      end
      TRAP: begin
        // Further overflows are masked here; epc keeps the first one.
        if (bus.trap_ack) begin
          state_d    = ACK;
          trap_req_d = 1'b0;
        end
      end
      ACK: begin
        ovf_clr = 1'b1;
        if (ovf_ev) begin
          state_d    = TRAP;
          epc_d      = bus.pc_in;
          trap_req_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        trap_req_d = 1'b0;
      end
    endcase
  end

  // Flag register: plain load, except the overflow bit is sticky and only
  // cleared in ACK; a new overflow in the same cycle beats the clear.
  always_comb begin
    flag_d = flag_q;
    if (bus.flag_we) begin
      flag_d = bus.nflag;
    end
    flag_d[OVF_BIT] = (flag_q[OVF_BIT] & ~ovf_clr) | ovf_ev;
  end

  // Branch resolution with same-cycle forwarding of nflag
  always_comb begin
    eff_z  = bus.flag_we ? bus.nflag[ZERO_BIT] : flag_q[ZERO_BIT];
    eff_ov = (bus.flag_we ? bus.nflag[OVF_BIT] : flag_q[OVF_BIT]) | flag_q[OVF_BIT];
    case (bus.br_cond)
      3'b000:  cond_res = eff_z;
      3'b001:  cond_res = ~eff_z;
      3'b010:  cond_res = eff_ov;
      3'b011:  cond_res = ~eff_ov;
      default: cond_res = 1'b1;
    endcase
    br_taken_d = bus.br_eval ? cond_res : br_taken_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      flag_q     <= '0;
      epc_q      <= '0;
      trap_req_q <= 1'b0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      epc_q      <= epc_d;
      trap_req_q <= trap_req_d;
      br_valid_q <= bus.br_eval;
      br_taken_q <= br_taken_d;
    end
  end

`ifdef FLAG_TRAP_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q;

  // Counts every overflow event, including those masked in TRAP; saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else if (ovf_ev && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`else
  assign bus.ovf_cnt = '0;
`endif

  assign bus.flag     = flag_q;
  assign bus.epc      = epc_q;
  assign bus.trap_req = trap_req_q;
  assign bus.br_valid = br_valid_q;
  assign bus.br_taken = br_taken_q;

endmodule
